// File: rtl/tune_player_pkg.sv
// Shared widths, note frequencies, tune IDs and ROM step layout for the tune player.
package tune_player_pkg;

  localparam int FREQ_W = 14;
  localparam int DUR_W  = 5;
  localparam int IDX_W  = 4;

  localparam logic [FREQ_W-1:0] NOTE_REST = 14'd0;
  localparam logic [FREQ_W-1:0] NOTE_A2   = 14'd110;
  localparam logic [FREQ_W-1:0] NOTE_C4   = 14'd262;
  localparam logic [FREQ_W-1:0] NOTE_E4   = 14'd330;
  localparam logic [FREQ_W-1:0] NOTE_G4   = 14'd392;
  localparam logic [FREQ_W-1:0] NOTE_C5   = 14'd523;
  localparam logic [FREQ_W-1:0] NOTE_E5   = 14'd659;
  localparam logic [FREQ_W-1:0] NOTE_G5   = 14'd784;
  localparam logic [FREQ_W-1:0] NOTE_A5   = 14'd880;
  localparam logic [FREQ_W-1:0] NOTE_C6   = 14'd1047;

  localparam logic [1:0] TUNE_DROP = 2'd0;
  localparam logic [1:0] TUNE_WIN  = 2'd1;
  localparam logic [1:0] TUNE_LOSE = 2'd2;
  localparam logic [1:0] TUNE_BAD  = 2'd3;

  // dur == 0 marks the end of a tune
  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } step_t;

  function automatic step_t mk_step(input logic [FREQ_W-1:0] f, input logic [DUR_W-1:0] d);
    return step_t'{freq: f, dur: d};
  endfunction

endpackage

// File: rtl/tune_player_if.sv
// Game-FSM to tune-player link: start/stop request in, buzzer drive and status out.
interface tune_player_if;
  import tune_player_pkg::*;

  logic              play;
  logic              stop;
  logic [1:0]        tune_sel;
  logic [FREQ_W-1:0] note;
  logic              enable;
  logic              busy;
  logic              done;

  modport master (output play, stop, tune_sel, input note, enable, busy, done);
  modport slave  (input play, stop, tune_sel, output note, enable, busy, done);
endinterface

// File: rtl/tune_player_melody_rom.sv
// Tune ROM: {tune, step index} -> {frequency in Hz, duration in ticks}.
module melody_rom
  import tune_player_pkg::*;
(
  input  logic [1:0]       tune_sel_i,
  input  logic [IDX_W-1:0] idx_i,
  output step_t            step_o
);

  always_comb begin
    step_o = mk_step(NOTE_REST, 5'd0);
    case ({tune_sel_i, idx_i})
      {TUNE_DROP, 4'd0}: step_o = mk_step(NOTE_A5, 5'd2);
      {TUNE_WIN,  4'd0}: step_o = mk_step(NOTE_C5, 5'd5);
      {TUNE_WIN,  4'd1}: step_o = mk_step(NOTE_E5, 5'd5);
      {TUNE_WIN,  4'd2}: step_o = mk_step(NOTE_G5, 5'd5);
      {TUNE_WIN,  4'd3}: step_o = mk_step(NOTE_C6, 5'd10);
      {TUNE_LOSE, 4'd0}: step_o = mk_step(NOTE_G4, 5'd8);
      {TUNE_LOSE, 4'd1}: step_o = mk_step(NOTE_REST, 5'd2);
      {TUNE_LOSE, 4'd2}: step_o = mk_step(NOTE_E4, 5'd8);
      {TUNE_LOSE, 4'd3}: step_o = mk_step(NOTE_C4, 5'd16);
      {TUNE_BAD,  4'd0}: step_o = mk_step(NOTE_A2, 5'd10);
      default:           step_o = mk_step(NOTE_REST, 5'd0);
    endcase
  end

endmodule

// File: rtl/tune_player.sv
// Melody sequencer: walks a ROM tune, driving buzzer note/enable with timed notes and gaps.
module tune_player
  import tune_player_pkg::*;
#(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int GAP_TICKS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tune_player_if.slave bus
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST   = DUR_W'(GAP_TICKS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_NOTE  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q, last_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DUR_W-1:0]  tick_q, tick_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [FREQ_W-1:0] note_q, note_d;
  logic              enable_q, enable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick_end;
  step_t             rom_step;

  melody_rom u_rom (
    .tune_sel_i (sel_q),
    .idx_i      (idx_q),
    .step_o     (rom_step)
  );

  assign tick_end = (presc_q == PRESC_LAST);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    last_d   = last_q;
    presc_d  = presc_q;
    tick_d   = tick_q;
    dur_d    = dur_q;
    note_d   = note_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.play && !bus.stop) begin
          sel_d   = bus.tune_sel;
          idx_d   = '0;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // last_q: all 16 steps played, treat as an end marker
        if (rom_step.dur == '0 || last_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          note_d   = rom_step.freq;
          enable_d = (rom_step.freq != '0);
          dur_d    = rom_step.dur;
          presc_d  = '0;
          tick_d   = '0;
          state_d  = S_NOTE;
        end
      end
      S_NOTE: begin
        presc_d = tick_end ? '0 : presc_q + 1'b1;
        if (tick_end) begin
          if (tick_q == dur_q - 5'd1) begin
            enable_d = 1'b0;
            tick_d   = '0;
            last_d   = (idx_q == '1);
            idx_d    = (idx_q == '1) ? idx_q : idx_q + 1'b1;
            state_d  = (GAP_TICKS > 0) ? S_GAP : S_FETCH;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        presc_d = tick_end ? '0 : presc_q + 1'b1;
        if (tick_end) begin
          if (tick_q == GAP_LAST) begin
            tick_d  = '0;
            state_d = S_FETCH;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
    endcase
    if (state_q != S_IDLE && bus.stop) begin
      state_d  = S_IDLE;
      enable_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      presc_q  <= '0;
      tick_q   <= '0;
      dur_q    <= '0;
      note_q   <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      dur_q    <= dur_d;
      note_q   <= note_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.note   = note_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: doc/tune_player.md
Name: tune_player

Overview:
- Melody sequencer sitting directly upstream of the buzzer tone generator.
- Drives its 14-bit note frequency (Hz) and enable inputs from a small tune ROM.
- Game FSM fires a one-cycle play pulse with a tune select (drop, win, lose, invalid-move).
- Block steps through the tune's notes with timed durations and inter-note gaps, then pulses done.

Parameters:
- TICK_CYCLES, 1_000_000, clock cycles per duration tick (20 ms at 50 MHz).
- GAP_TICKS, 1, silent ticks inserted after every note; 0 = no gap.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- play  input  1  one-cycle start request, sampled on rising clk.
- stop  input  1  abort current tune.
- tune_sel  input  2  tune index, latched when play is accepted.
- note  output  14  frequency to buzzer, Hz; 0 = rest.
- enable  output  1  buzzer enable.
- busy  output  1  tune in progress.
- done  output  1  one-cycle pulse on natural tune completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE; note=0, enable=0, busy=0, done=0; step index, tick prescaler and tick counter all 0.
- All outputs are registered.
- ROM step: 14-bit freq plus 5-bit dur (ticks); dur=0 is the end marker. Max 16 steps per tune, index 4 bits.
- FSM states: IDLE, FETCH, NOTE, GAP.
- IDLE:
  - play=1 and stop=0 at edge k: latch tune_sel, index=0, go to FETCH; busy=1 from k+1.
- FETCH (1 cycle, enable=0):
  - dur=0: done=1 for one cycle, busy=0, go to IDLE. note keeps its last value; it is don't-care when enable=0.
  - Otherwise: load note=freq; enable=1 iff freq!=0 (rests keep enable low); clear prescaler; go to NOTE.
  - Net effect: note/enable are valid 2 cycles after the accepted play edge.
- NOTE:
  - Lasts exactly dur*TICK_CYCLES cycles.
  - Prescaler counts 0..TICK_CYCLES-1; the tick counter counts ticks.
  - On the last cycle: enable=0, then go to GAP if GAP_TICKS>0, else to FETCH. Index increments.
- GAP:
  - enable=0, note held, for GAP_TICKS*TICK_CYCLES cycles, then FETCH.
- Index wrap: after step 15 completes, the sequence ends as if the next dur=0. Index does not wrap to 0.
- stop=1 in any non-IDLE state: next cycle enable=0, busy=0, state IDLE, no done pulse.
- play while busy is ignored.
- play and stop in the same cycle: stop wins; in IDLE, nothing starts.
- Reset mid-tune: immediate return to reset values. A later play restarts from step 0.
- Width rules:
  - Prescaler width = clog2(TICK_CYCLES).
  - Tick counter is 5 bits, compared against dur-1; no overflow possible.
- ROM contents (freq Hz / dur ticks):
  - tune 0 drop: 880/2, end.
  - tune 1 win: 523/5, 659/5, 784/5, 1047/10, end.
  - tune 2 lose: 392/8, 0/2, 330/8, 262/16, end.
  - tune 3 invalid: 110/10, end.

Decomposition:
- Shared include: localparams for note frequencies (NOTE_C5=523 etc.), tune IDs (TUNE_DROP=0, TUNE_WIN=1, TUNE_LOSE=2, TUNE_BAD=3), and field widths (FREQ_W=14, DUR_W=5, IDX_W=4).
- Sub-module melody_rom: combinational case on {tune_sel, index}, returning {freq, dur}.
- The FSM, prescaler and output registers stay in tune_player.

Test Plan (TICK_CYCLES=4, GAP_TICKS=1):
- Assert rst_n=0 mid-operation with random inputs -> note=0, enable=0, busy=0, done=0 immediately; all stay 0 with play=0 after release.
- play, tune_sel=0 at edge k -> busy=1 at k+1; note=880 with enable=1 from k+2 for 8 cycles; enable=0 for 4 gap cycles + 1 fetch cycle; done=1 for one cycle with busy=0 simultaneously; no further enable.
- tune_sel=1 -> enable-high windows with note = 523, 659, 784, 1047, lasting 20, 20, 20, 40 cycles; each window separated by exactly 5 enable-low cycles; exactly one done pulse.
- tune_sel=2 -> the rest step keeps enable=0 for 8+5 cycles between the 392 and 330 notes; total busy duration matches the sum of durations, gaps and fetch cycles.
- stop during the second note of tune 1 -> enable=0 and busy=0 next cycle; no done pulse; a new play restarts at 523.
- play pulses while busy -> ignored, sequence unchanged; play+stop in the same cycle while IDLE -> busy stays 0.
